mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
//  Initiator side of the word memory port (ren/wen/addr/din/dout). Takes one load/store
//  request at a time from the CPU datapath, sequences the memory strobes so ren and wen are
//  never high together and addr/din stay stable around every strobe, and returns a one-cycle
//  response carrying read data or an error flag. Sits between the CPU datapath and the Memory block.
// PARAMETERS
//  STROBE_CYCLES  1   cycles ren/wen is held high per access; legal range 1..15
//  ADDR_W         32  request/memory address width
//  DATA_W         32  data width
// PORTS
//  clock       in   1       system clock; all state changes on posedge
//  reset       in   1       asynchronous, active-low reset
//  req_valid   in   1       CPU request present
//  req_ready   out  1       high only in IDLE; request accepted on posedge with req_valid && req_ready
//  req_write   in   1       1 = store, 0 = load
//  req_addr    in   ADDR_W  byte address; must be word aligned
//  req_wdata   in   DATA_W  store data
//  resp_valid  out  1       one-cycle response pulse; no backpressure
//  resp_error  out  1       qualifies resp_valid: request rejected, no memory access made
//  resp_rdata  out  DATA_W  load data; 0 for stores and errors
//  mem_ren     out  1       memory read enable
//  mem_wen     out  1       memory write enable
//  mem_addr    out  ADDR_W  memory address (byte address passed through unchanged)
//  mem_din     out  DATA_W  memory write data
//  mem_dout    in   DATA_W  memory read data (combinational from memory)
// BEHAVIOUR
//  Reset (async, reset==0): FSM->IDLE; req_ready=1; resp_valid=resp_error=0; resp_rdata=0;
//   mem_ren=mem_wen=0; mem_addr=mem_din=0; strobe counter=0. Mid-access reset drops strobes
//   immediately; the in-flight request is discarded, no response is issued.
//  On accept: req_write/addr/wdata registered; mem_addr/mem_din driven from these registers
//   and held constant until the FSM returns to IDLE.
//  FSM: IDLE --accept, aligned--> SETUP;  IDLE --accept, addr[1:0]!=0--> ERR
//   SETUP (1 cycle): addr/din stable, ren=wen=0 -> STROBE
//   STROBE (STROBE_CYCLES cycles): mem_ren=~wr or mem_wen=wr; counter counts up -> HOLD on last
//   HOLD (1 cycle): strobes low, addr/din still held; resp_valid=1 -> IDLE
//   ERR (1 cycle): resp_valid=1, resp_error=1, no strobes -> IDLE
//  Latency (cycles after accept edge): good access resp_valid in cycle STROBE_CYCLES+2;
//   error in cycle 1. Throughput: one access per STROBE_CYCLES+3 cycles (IDLE cycle included).
//  Load data: resp_rdata <= mem_dout at posedge ending the last STROBE cycle; holds until the
//   next response (cleared to 0 by store/error responses).
//  Invariants: mem_ren&&mem_wen never 1; strobes only asserted in STROBE; mem_addr/mem_din
//   change only in IDLE; resp_valid width exactly 1 cycle.
//  req_valid while busy: ignored (req_ready=0); CPU holds request until accepted.
//  req_valid deasserted without accept: no effect.
// CONFIGURATION
//  MEM_ACCESS_RANGE_CHECK_EN defined: req_addr[ADDR_W-1:12]!=0 also routes to ERR (no strobes).
//  Undefined: only alignment is checked; upper address bits pass to mem_addr unchanged.
// STRUCTURE
//  constants.h: FSM state encodings (IDLE, SETUP, STROBE, HOLD, ERR) and the
//   memory-window bound (12 address bits).
//  Sub-module mem_strobe_timer: loadable up-counter asserting done after STROBE_CYCLES
//   cycles; cleared by reset and on entry to STROBE.
// TESTING
//  1 Reset: reset=0 mid-STROBE of a store -> mem_wen falls same time step, no resp_valid,
//    req_ready=1 after release.
//  2 Store then load: write addr 0x10 data 0xDEADBEEF, read 0x10 -> resp_rdata=0xDEADBEEF,
//    resp_valid in cycle 3 after accept (STROBE_CYCLES=1), resp_error=0 for both.
//  3 Misaligned: load addr 0x0000_0006 -> resp_valid=resp_error=1 in cycle 1, mem_ren/mem_wen
//    never asserted, resp_rdata=0.
//  4 Busy: req_valid held through a load with STROBE_CYCLES=3 -> second request accepted only
//    after returning to IDLE; accept edges 6 cycles apart.
//  5 Range (MEM_ACCESS_RANGE_CHECK_EN): store to 0x0000_1000 -> error, no wen; without macro
//    -> normal store, resp_error=0.
//  6 Invariant checker on every cycle: !(mem_ren&&mem_wen); mem_addr/mem_din stable while
//    FSM!=IDLE.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_unit_pkg
// Shared definitions for the memory access unit: FSM state encodings, the
// memory-window bound used by the optional range check, the strobe counter
// width and a small address-alignment helper.
// No ports (package).
// -----------------------------------------------------------------------------
package mem_access_unit_pkg;

  // Access sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_ERR    = 3'd4
  } mau_state_e;

  // Addresses at or above 2**MEM_WINDOW_BITS fall outside the memory window.
  localparam int unsigned MEM_WINDOW_BITS = 12;

  // Wide enough for the largest legal strobe length (15).
  localparam int unsigned STROBE_CNT_W = 4;

  // A word access is legal only when the two byte-offset bits are zero.
  function automatic logic word_aligned(input logic [1:0] lsbs);
    return (lsbs == 2'b00);
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// -----------------------------------------------------------------------------
// mem_access_unit_if
// Bundles the CPU request/response handshake and the word memory port.
//   master : view of the access unit (accepts requests, drives responses and
//            the memory strobes/address/data, reads mem_dout)
//   slave  : view of the environment (CPU datapath plus memory)
// Parameters: ADDR_W address width, DATA_W data width.
// -----------------------------------------------------------------------------
interface mem_access_unit_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_error;
  logic [DATA_W-1:0] resp_rdata;
  logic              mem_ren;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, mem_dout,
    output req_ready, resp_valid, resp_error, resp_rdata,
           mem_ren, mem_wen, mem_addr, mem_din
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, mem_dout,
    input  req_ready, resp_valid, resp_error, resp_rdata,
           mem_ren, mem_wen, mem_addr, mem_din
  );

endinterface

// File: rtl/mem_access_unit_strobe_timer.sv
// -----------------------------------------------------------------------------
// mem_strobe_timer
// Up-counter that measures the length of a memory strobe.
//   clock  in  system clock
//   reset  in  asynchronous active-low reset (count -> 0)
//   clr    in  reload count to 0 (asserted the cycle before the strobe starts)
//   en     in  strobe active; count advances each cycle
//   done   out high during the last strobe cycle (count == STROBE_CYCLES-1)
// Parameter: STROBE_CYCLES strobe length, 1..15.
// -----------------------------------------------------------------------------
module mem_strobe_timer
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned STROBE_CYCLES = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam logic [STROBE_CNT_W-1:0] LAST_COUNT = STROBE_CNT_W'(STROBE_CYCLES - 1);

  logic [STROBE_CNT_W-1:0] count_r;

  // Strobe cycle counter: cleared on reset or reload, advances while enabled.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_r <= {STROBE_CNT_W{1'b0}};
    end else if (clr) begin
      count_r <= {STROBE_CNT_W{1'b0}};
    end else if (en) begin
      count_r <= count_r + {{(STROBE_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign done = en && (count_r == LAST_COUNT);

endmodule

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Initiator side of the word memory port. Accepts one load/store at a time,
// sequences SETUP -> STROBE -> HOLD so that ren/wen never overlap and the
// address/data are stable around every strobe, then returns a one-cycle
// response with load data or an error flag.
// Ports:
//   clock  in  system clock
//   reset  in  asynchronous active-low reset
//   bus    mem_access_unit_if.master: req_valid/ready/write/addr/wdata,
//          resp_valid/error/rdata, mem_ren/wen/addr/din/dout
// Parameters: STROBE_CYCLES (1..15), ADDR_W (> 12), DATA_W.
// Build option: define MEM_ACCESS_RANGE_CHECK_EN to also reject addresses
// outside the 4 KiB memory window.
// -----------------------------------------------------------------------------
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned STROBE_CYCLES = 1,
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned DATA_W        = 32
) (
  input  logic              clock,
  input  logic              reset,
  mem_access_unit_if.master bus
);

  mau_state_e        state_r;
  logic              write_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic              ready_r;
  logic              resp_valid_r;
  logic              resp_error_r;
  logic [DATA_W-1:0] rdata_r;
  logic              ren_r;
  logic              wen_r;

  logic              accept_s;
  logic              range_err_s;
  logic              bad_req_s;
  logic              timer_clr_s;
  logic              timer_en_s;
  logic              timer_done_s;

  assign accept_s = bus.req_valid && ready_r;

`ifdef MEM_ACCESS_RANGE_CHECK_EN
  assign range_err_s = (bus.req_addr[ADDR_W-1:MEM_WINDOW_BITS] != {(ADDR_W-MEM_WINDOW_BITS){1'b0}});
`else
  assign range_err_s = 1'b0;
`endif

  // Classify the offered request as rejectable (misaligned or out of window).
  always_comb begin
    bad_req_s = 1'b0;
    if (!word_aligned(bus.req_addr[1:0]) || range_err_s) begin
      bad_req_s = 1'b1;
    end else begin
      bad_req_s = 1'b0;
    end
  end

  // The counter is reloaded in SETUP so it starts from zero on STROBE entry.
  assign timer_clr_s = (state_r == ST_SETUP);
  assign timer_en_s  = (state_r == ST_STROBE);

  mem_strobe_timer #(
    .STROBE_CYCLES (STROBE_CYCLES)
  ) u_strobe_timer (
    .clock (clock),
    .reset (reset),
    .clr   (timer_clr_s),
    .en    (timer_en_s),
    .done  (timer_done_s)
  );

  // Access sequencer with registered strobes, handshake and response outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      write_r      <= 1'b0;
      addr_r       <= {ADDR_W{1'b0}};
      wdata_r      <= {DATA_W{1'b0}};
      ready_r      <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_error_r <= 1'b0;
      rdata_r      <= {DATA_W{1'b0}};
      ren_r        <= 1'b0;
      wen_r        <= 1'b0;
    end else begin
      // Response is a single-cycle pulse unless re-asserted below.
      resp_valid_r <= 1'b0;
      resp_error_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            // Address/data are captured even for rejected requests; the
            // capture only ever happens in IDLE, so the memory side sees no
            // change during an access.
            write_r <= bus.req_write;
            addr_r  <= bus.req_addr;
            wdata_r <= bus.req_wdata;
            ready_r <= 1'b0;
            if (bad_req_s) begin
              state_r      <= ST_ERR;
              resp_valid_r <= 1'b1;
              resp_error_r <= 1'b1;
              rdata_r      <= {DATA_W{1'b0}};
            end else begin
              state_r <= ST_SETUP;
            end
          end
        end
        ST_SETUP: begin
          state_r <= ST_STROBE;
          ren_r   <= ~write_r;
          wen_r   <= write_r;
        end
        ST_STROBE: begin
          if (timer_done_s) begin
            state_r      <= ST_HOLD;
            ren_r        <= 1'b0;
            wen_r        <= 1'b0;
            resp_valid_r <= 1'b1;
            // Load data is sampled while ren is still high.
            rdata_r      <= write_r ? {DATA_W{1'b0}} : bus.mem_dout;
          end
        end
        ST_HOLD: begin
          state_r <= ST_IDLE;
          ready_r <= 1'b1;
        end
        ST_ERR: begin
          state_r <= ST_IDLE;
          ready_r <= 1'b1;
        end
        default: begin
          state_r <= ST_IDLE;
          ready_r <= 1'b1;
          ren_r   <= 1'b0;
          wen_r   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready  = ready_r;
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_error = resp_error_r;
  assign bus.resp_rdata = rdata_r;
  assign bus.mem_ren    = ren_r;
  assign bus.mem_wen    = wen_r;
  assign bus.mem_addr   = addr_r;
  assign bus.mem_din    = wdata_r;

endmodule
